// File: rtl/z80_io_initiator.sv
// Z80-style I/O bus initiator: turns valid/ready commands into IN/OUT cycles.
// Ports: clk, reset_n; cmd_* request; rsp_* response; a_out/iorq_n/rd_n/wr_n/cd_* bus; wait_n.
module z80_io_initiator #(
    parameter int CLK_DIV  = 8,
    parameter int GAP      = 4,
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] a_out,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] cd_out,
    output logic       cd_oe,
    input  logic [7:0] cd_in,
    input  logic       wait_n
);
    localparam int CMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = $clog2(CMAX);
    localparam int WW   = $clog2(MAX_WAIT + 2);

    localparam logic [CW-1:0] TLAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GLAST = CW'(GAP - 1);
    localparam logic [WW-1:0] WMAX  = WW'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3,
        S_REC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    logic          write_q, write_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          rdy_en_q;
    logic          sync1_q, sync2_q;

    logic tlast;
    logic strb;

    assign tlast = (tcnt_q == TLAST);

    // Ready is held low during reset and rises on the first clock after release.
    assign cmd_ready = (state_q == S_IDLE) & rdy_en_q;

    assign strb   = (state_q == S_T2) | (state_q == S_TW) | (state_q == S_T3);
    assign iorq_n = ~strb;
    assign rd_n   = ~(strb & ~write_q);
    assign wr_n   = ~(strb & write_q);

    // Write data is driven from T1 and held one clock into RECOVER.
    assign cd_oe = write_q & ((state_q == S_T1) | strb |
                              ((state_q == S_REC) & (tcnt_q == '0)));
    assign cd_out = wdata_q;
    assign a_out  = addr_q;

    assign rsp_valid = (state_q == S_REC) & (tcnt_q == '0);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q + CW'(1);
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                if (tlast) begin
                    tcnt_d  = '0;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                if (tlast) begin
                    tcnt_d  = '0;
                    state_d = S_TW;
                end
            end
            S_TW: begin
                if (tlast) begin
                    tcnt_d = '0;
                    if (sync2_q) begin
                        state_d = S_T3;
                    end else if (wcnt_q == WMAX) begin
                        err_d   = 1'b1;
                        state_d = S_REC;
                    end else begin
                        wcnt_d = wcnt_q + WW'(1);
                    end
                end
            end
            S_T3: begin
                if (tlast) begin
                    tcnt_d = '0;
                    if (!write_q) begin
                        rdata_d = cd_in;
                    end
                    state_d = S_REC;
                end
            end
            S_REC: begin
                if (tcnt_q == GLAST) begin
                    tcnt_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tcnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rdy_en_q <= 1'b0;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rdy_en_q <= 1'b1;
            sync1_q  <= wait_n;
            sync2_q  <= sync1_q;
        end
    end

endmodule
